// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: parallel-in / serial-out stage feeding the 1001 detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out MSB-first on
// ser_out, with frame_start/frame_done markers and an optional idle gap of
// GAP_CYCLES between frames.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready never depends on in_valid, and in_data is sampled only on that edge.
//
// Optional feature, macro SER_PARITY_EN: appends one even-parity bit after the
// data bits; frame_done and the back-to-back in_ready window move to it.
module piso_bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BITS);
    localparam logic [3:0]        GAP_LAST = 4'(GAP_CYCLES);
    localparam logic              NO_GAP   = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg_q;    // bits still to be sent, next one at MSB
    logic [CNT_W-1:0]   bit_cnt_q;  // frame bits already placed on ser_out
    logic [3:0]         gap_cnt_q;  // gap cycles already spent
    logic               last_bit;
    logic               gap_last;
    logic               load;
    logic               advance;
`ifdef SER_PARITY_EN
    logic               parity_q;
`endif

    // State register: asynchronous abort of any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a handshake always starts a fresh frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (load)         state_d = ST_SHIFT;
                    else if (!NO_GAP) state_d = ST_GAP;
                    else              state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_last) state_d = load ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs: ready windows, handshake and shift strobes.
    always_comb begin
        last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT);
        gap_last = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
        in_ready = reset_n && ((state_q == ST_IDLE) || (last_bit && NO_GAP) || gap_last);
        load     = in_valid && in_ready;
        advance  = (state_q == ST_SHIFT) && !last_bit;
        busy     = (state_q != ST_IDLE);
    end

    // Datapath: load places the MSB immediately; advance shifts one bit per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ser_out     <= IDLE_LEVEL;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else if (load) begin
            shreg_q     <= {in_data[WIDTH-2:0], 1'b0};
            bit_cnt_q   <= CNT_W'(1);
            gap_cnt_q   <= '0;
            ser_out     <= in_data[WIDTH-1];
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            frame_done  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= ^in_data;
`endif
        end else if (advance) begin
            shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
`ifdef SER_PARITY_EN
            ser_out     <= (bit_cnt_q == CNT_W'(WIDTH)) ? parity_q : shreg_q[WIDTH-1];
`else
            ser_out     <= shreg_q[WIDTH-1];
`endif
            ser_valid   <= 1'b1;
            frame_start <= 1'b0;
            frame_done  <= (bit_cnt_q == LAST_CNT - CNT_W'(1));
        end else begin
            bit_cnt_q   <= '0;
            ser_out     <= IDLE_LEVEL;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (last_bit && !NO_GAP) begin
                gap_cnt_q <= 4'd1;
            end else if ((state_q == ST_GAP) && !gap_last) begin
                gap_cnt_q <= gap_cnt_q + 4'd1;
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: instance a with no gap, instance b with a
// two-cycle gap. Expected {frame_start, frame_done, bit} triples are queued when
// a handshake is seen and popped by a per-instance monitor on every valid bit.
module tb_piso_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_data_a, in_data_b;
    logic         in_valid_a, in_valid_b;
    logic         in_ready_a, in_ready_b;
    logic         ser_out_a, ser_out_b;
    logic         ser_valid_a, ser_valid_b;
    logic         frame_start_a, frame_start_b;
    logic         frame_done_a, frame_done_b;
    logic         busy_a, busy_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cycle_cnt = 0;

    logic [2:0] exp_a[$];
    logic [2:0] exp_b[$];

    piso_bit_serializer #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a),
        .frame_start(frame_start_a), .frame_done(frame_done_a), .busy(busy_a)
    );

    piso_bit_serializer #(.WIDTH(W), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
        .frame_start(frame_start_b), .frame_done(frame_done_b), .busy(busy_b)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Scoreboard monitor for instance a
    always @(negedge clk) begin
        logic [2:0] e;
        if (reset_n === 1'b1) begin
            total_cnt++;
            if (ser_valid_a === 1'b1) begin
                if (exp_a.size() == 0) begin
                    $display("FAIL mon_a_unexpected: got bit %b with no word queued", ser_out_a);
                end else begin
                    e = exp_a.pop_front();
                    if ({frame_start_a, frame_done_a, ser_out_a} !== e)
                        $display("FAIL mon_a_bit: got start/done/bit %b want %b (t=%0t)",
                                 {frame_start_a, frame_done_a, ser_out_a}, e, $time);
                    else pass_cnt++;
                end
            end else if ({frame_start_a, frame_done_a, ser_out_a, ser_valid_a} !== 4'b0000) begin
                $display("FAIL mon_a_idle: got start/done/out/valid %b want 0000 (t=%0t)",
                         {frame_start_a, frame_done_a, ser_out_a, ser_valid_a}, $time);
            end else pass_cnt++;
        end
    end

    // Scoreboard monitor for instance b
    always @(negedge clk) begin
        logic [2:0] e;
        if (reset_n === 1'b1) begin
            total_cnt++;
            if (ser_valid_b === 1'b1) begin
                if (exp_b.size() == 0) begin
                    $display("FAIL mon_b_unexpected: got bit %b with no word queued", ser_out_b);
                end else begin
                    e = exp_b.pop_front();
                    if ({frame_start_b, frame_done_b, ser_out_b} !== e)
                        $display("FAIL mon_b_bit: got start/done/bit %b want %b (t=%0t)",
                                 {frame_start_b, frame_done_b, ser_out_b}, e, $time);
                    else pass_cnt++;
                end
            end else if ({frame_start_b, frame_done_b, ser_out_b, ser_valid_b} !== 4'b0000) begin
                $display("FAIL mon_b_idle: got start/done/out/valid %b want 0000 (t=%0t)",
                         {frame_start_b, frame_done_b, ser_out_b, ser_valid_b}, $time);
            end else pass_cnt++;
        end
    end

    // Queue the expected frame for a word that has just been accepted
    task automatic push_word(input logic sel, input logic [W-1:0] w);
        logic [2:0] e;
        for (int i = W - 1; i >= 0; i--) begin
            e = {(i == W - 1), ((i == 0) && (FB == W)), w[i]};
            if (sel) exp_b.push_back(e); else exp_a.push_back(e);
        end
`ifdef SER_PARITY_EN
        e = {1'b0, 1'b1, ^w};
        if (sel) exp_b.push_back(e); else exp_a.push_back(e);
`endif
    endtask

    // Driver: offer a word, wait for the handshake edge, return just after it
    // with in_valid still asserted.
    task automatic send(input logic sel, input logic [W-1:0] w, output int hs_cyc);
        logic got;
        got    = 1'b0;
        hs_cyc = -1;
        if (sel) begin in_valid_b = 1'b1; in_data_b = w; end
        else     begin in_valid_a = 1'b1; in_data_a = w; end
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if ((sel ? in_ready_b : in_ready_a) === 1'b1) begin
                push_word(sel, w);
                hs_cyc = cycle_cnt;
                got    = 1'b1;
            end
        end
        total_cnt++;
        if (!got) $display("FAIL handshake_%s: in_ready got 0 for 60 cycles want 1", sel ? "b" : "a");
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an instance's expected queue to empty
    task automatic drain(input logic sel);
        int left;
        left = sel ? exp_b.size() : exp_a.size();
        for (int k = 0; k < 60 && left != 0; k++) begin
            @(negedge clk);
            #1;
            left = sel ? exp_b.size() : exp_a.size();
        end
        @(negedge clk);
        total_cnt++;
        if (left != 0) $display("FAIL drain_%s: got %0d bits outstanding want 0", sel ? "b" : "a", left);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0;
        in_valid_b = 1'b0; in_data_b = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({ser_out_a, ser_valid_a, frame_start_a, frame_done_a, busy_a, in_ready_a} !== 6'b0)
            $display("FAIL reset_a: got out/valid/start/done/busy/ready %b want 000000",
                     {ser_out_a, ser_valid_a, frame_start_a, frame_done_a, busy_a, in_ready_a});
        else pass_cnt++;
        total_cnt++;
        if ({ser_out_b, ser_valid_b, busy_b, in_ready_b} !== 4'b0)
            $display("FAIL reset_b: got out/valid/busy/ready %b want 0000",
                     {ser_out_b, ser_valid_b, busy_b, in_ready_b});
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({in_ready_a, in_ready_b} !== 2'b11)
            $display("FAIL ready_after_reset: got %b want 11", {in_ready_a, in_ready_b});
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int hs;
        send(1'b0, 8'h9A, hs);
        in_valid_a = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy_a, in_ready_a} !== 2'b10)
            $display("FAIL single_busy: got busy/ready %b want 10", {busy_a, in_ready_a});
        else pass_cnt++;
        drain(1'b0);
        total_cnt++;
        if ({busy_a, in_ready_a} !== 2'b01)
            $display("FAIL single_idle: got busy/ready %b want 01", {busy_a, in_ready_a});
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int h1, h2;
        send(1'b0, 8'h90, h1);
        send(1'b0, 8'h09, h2);
        in_valid_a = 1'b0;
        total_cnt++;
        if (h2 - h1 != FB) $display("FAIL b2b_spacing: got %0d cycles want %0d", h2 - h1, FB);
        else pass_cnt++;
        drain(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_hold_data();
        int hs_cnt;
        hs_cnt     = 0;
        in_valid_a = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data_a = W'($urandom_range(0, (1 << W) - 1));
            @(negedge clk);
            if (in_ready_a === 1'b1) begin
                push_word(1'b0, in_data_a);
                hs_cnt++;
            end
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        total_cnt++;
        if (hs_cnt != 3) $display("FAIL hold_handshakes: got %0d want 3", hs_cnt);
        else pass_cnt++;
        drain(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_gap();
        int   hs;
        logic exp_rdy, exp_vld;
        send(1'b1, 8'hFF, hs);
        in_data_b = 8'h00;
        for (int c = 1; c <= FB + 3; c++) begin
            @(negedge clk);
            exp_rdy = (c == FB + 2);
            exp_vld = (c <= FB) || (c == FB + 3);
            total_cnt++;
            if ({in_ready_b, ser_valid_b} !== {exp_rdy, exp_vld})
                $display("FAIL gap_c%0d: got ready/valid %b want %b", c,
                         {in_ready_b, ser_valid_b}, {exp_rdy, exp_vld});
            else pass_cnt++;
            if (c == FB + 2 && in_ready_b === 1'b1) push_word(1'b1, 8'h00);
        end
        in_valid_b = 1'b0;
        drain(1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int hs;
        send(1'b0, 8'h9A, hs);
        in_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({ser_valid_a, ser_out_a, in_ready_a, frame_done_a, busy_a} !== 5'b0)
            $display("FAIL reset_mid: got valid/out/ready/done/busy %b want 00000",
                     {ser_valid_a, ser_out_a, in_ready_a, frame_done_a, busy_a});
        else pass_cnt++;
        exp_a.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 8'h81, hs);
        in_valid_a = 1'b0;
        drain(1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_data();
        test_gap();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (exp_a.size() + exp_b.size() != 0)
            $display("FAIL final_queues: got %0d bits outstanding want 0", exp_a.size() + exp_b.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 1001 sequence detector; its ser_out drives the detector's data_in, one bit per clk.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first.
- Inserts a configurable idle gap between frames.
- Provides frame_start/frame_done markers so downstream logic and benches can align detector output to word boundaries.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- GAP_CYCLES, 0, idle cycles forced between consecutive frames; legal range 0..15.
- IDLE_LEVEL, 1'b0, value driven on ser_out whenever no frame bit is being sent.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  word to serialize; sampled only on handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle; combinational from state.
- ser_out  output  1  serial bit to detector data_in; registered.
- ser_valid  output  1  ser_out carries a frame bit; registered.
- frame_start  output  1  one-cycle pulse coincident with the first bit of a frame; registered.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame; registered.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset and reset values:
  - reset_n is asynchronous and active-low; clk is the only clock.
  - While reset_n is low: state=IDLE, shift register=0, bit counter=0, ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0, frame_done=0, busy=0, in_ready=0 (forced).
  - in_ready rises in the first cycle after reset_n deasserts.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready at edge N: load in_data, go to SHIFT.
    - After edge N: ser_out=in_data[WIDTH-1], ser_valid=1, frame_start=1.
  - SHIFT:
    - One bit per cycle, MSB-first; the bit counter counts frame bits sent.
    - The last bit (index 0) has frame_done=1.
    - Frame occupies exactly WIDTH consecutive ser_valid cycles.
  - GAP:
    - Entered after the last bit only if GAP_CYCLES>0.
    - Lasts exactly GAP_CYCLES cycles with ser_out=IDLE_LEVEL and ser_valid=0.
    - Then go to IDLE, or start the next frame directly if a handshake happens.
- in_ready:
  - High in IDLE.
  - High in SHIFT on the last-bit cycle only when GAP_CYCLES==0.
  - High in GAP on the final gap cycle.
  - Low otherwise.
- Back-to-back handshake: a handshake while in_ready is high in SHIFT or GAP loads the next word. Its MSB appears in the very next cycle with frame_start=1, so there is no bubble when GAP_CYCLES==0.
- No frame pending: when no handshake occurs at frame end (GAP_CYCLES==0) or on the final gap cycle, return to IDLE. ser_out=IDLE_LEVEL and ser_valid=0 from the next cycle.
- in_data/in_valid changes while in_ready=0 are ignored; the loaded word is not affected.
- WIDTH==2 with GAP_CYCLES==0: frame_start and frame_done fall on adjacent cycles, never the same cycle.
- Reset mid-frame:
  - The frame is aborted immediately (asynchronous).
  - No frame_done for the aborted frame.
  - The next accepted word starts a fresh frame.
- Bit counter width: clog2(WIDTH+1); gap counter 4 bits; no wrap beyond terminal counts.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one extra bit is sent with ser_valid=1.
  - Extra bit value = ^word_loaded (even parity: total ones in frame even).
  - frame_done moves to the parity bit; frame is WIDTH+1 cycles.
  - in_ready back-to-back window moves to the parity cycle.
- When undefined: no parity bit, no parity logic synthesized; behaviour as above.

Test Plan:
- WIDTH=8, GAP=0, in_data=8'h9A, one handshake -> ser_out 1,0,0,1,1,0,1,0 on 8 consecutive cycles starting the cycle after handshake; frame_start on bit 1, frame_done on bit 8; then ser_out=0, ser_valid=0.
- GAP=0, words 8'h90 then 8'h09 with in_valid held -> 16 contiguous ser_valid cycles 1001_0000_0000_1001; frame_start at cycles 1 and 9; chained detector reports 1001 twice.
- GAP=2, words 8'hFF, 8'h00 back-to-back offered -> 8 ones, exactly 2 cycles ser_valid=0 / ser_out=0, then 8 zeros; in_ready high only on the 2nd gap cycle.
- in_data toggled every cycle while busy, in_valid=1 -> transmitted bits match only the word captured at handshake.
- reset_n pulsed low after bit 3 of 8'h9A -> ser_valid=0, ser_out=0, in_ready=0 immediately; no frame_done; after release 8'h81 serializes cleanly from MSB.
- SER_PARITY_EN, 8'h9A then 8'h98 -> 9-bit frames with parity 0 then 1; frame_done on the 9th bit of each.
